// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - IF stage with prefetch queue, in-order imem requests and redirect squash
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]   pc_f_q, pc_f_d;
    logic [XLEN-1:0]   slot_pc_q    [QDEPTH];
    logic [XLEN-1:0]   slot_instr_q [QDEPTH];
    logic [QDEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]     alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]     unans_q, unans_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0]   instr_q, instr_d_n, pc_q, pc_d_n, pc_plus4_q, pc_plus4_d_n;
    logic              valid_q, valid_d_n;

    logic req_fire, rsp_drop, rsp_fill, head_filled, pop;

    // Held low during reset so no request escapes before state is known
    assign imem_req_valid = arst_n & ~stall_f & ~pcsrc_e & (alloc_cnt_q < CW'(QDEPTH));
    assign imem_req_addr  = pc_f_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_drop       = imem_rsp_valid & (drop_cnt_q != '0);
    assign rsp_fill       = imem_rsp_valid & (drop_cnt_q == '0) & (unans_q != '0);
    assign head_filled    = filled_q[head_q];
    assign pop            = ~pcsrc_e & ~flush_d & ~stall_d & head_filled;

    always_comb begin
        pc_f_d      = pc_f_q;
        filled_d    = filled_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        alloc_cnt_d = alloc_cnt_q;
        unans_d     = unans_q;
        drop_cnt_d  = drop_cnt_q;
        if (pcsrc_e) begin
            pc_f_d      = pc_target_e & ~XLEN'(3);
            filled_d    = '0;
            head_d      = '0;
            tail_d      = '0;
            fill_d      = '0;
            alloc_cnt_d = '0;
            unans_d     = '0;
            // Every unanswered request still owes a response; one may be arriving now
            drop_cnt_d  = drop_cnt_q + unans_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc_f_d = pc_f_q + XLEN'(4);
            alloc_cnt_d = alloc_cnt_q + CW'(req_fire) - CW'(pop);
            unans_d     = unans_q + CW'(req_fire) - CW'(rsp_fill);
            drop_cnt_d  = drop_cnt_q - CW'(rsp_drop);
            head_d      = head_q + PW'(pop);
            tail_d      = tail_q + PW'(req_fire);
            fill_d      = fill_q + PW'(rsp_fill);
            if (pop)      filled_d[head_q] = 1'b0;
            if (rsp_fill) filled_d[fill_q] = 1'b1;
        end
    end

    always_comb begin
        instr_d_n    = instr_q;
        pc_d_n       = pc_q;
        pc_plus4_d_n = pc_plus4_q;
        valid_d_n    = valid_q;
        if (pcsrc_e || flush_d || (!stall_d && !head_filled)) begin
            instr_d_n    = '0;
            pc_d_n       = '0;
            pc_plus4_d_n = '0;
            valid_d_n    = 1'b0;
        end else if (!stall_d) begin
            instr_d_n    = slot_instr_q[head_q];
            pc_d_n       = slot_pc_q[head_q];
            pc_plus4_d_n = slot_pc_q[head_q] + XLEN'(4);
            valid_d_n    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_f_q      <= RESET_PC;
            filled_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
            unans_q     <= '0;
            drop_cnt_q  <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            filled_q    <= filled_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            alloc_cnt_q <= alloc_cnt_d;
            unans_q     <= unans_d;
            drop_cnt_q  <= drop_cnt_d;
            instr_q     <= instr_d_n;
            pc_q        <= pc_d_n;
            pc_plus4_q  <= pc_plus4_d_n;
            valid_q     <= valid_d_n;
        end
    end

    // Slot payload is qualified by filled_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (req_fire) slot_pc_q[tail_q]    <= pc_f_q;
        if (rsp_fill) slot_instr_q[fill_q] <= imem_rsp_data;
    end

    assign instr_d    = instr_q;
    assign pc_d       = pc_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - table-driven bench for fetch_queue_stage with a fixed-latency imem
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pcsrc_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    always #5 clk = ~clk;

    fetch_queue_stage #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .arst_n(arst_n), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pcsrc_e(pcsrc_e), .pc_target_e(pc_target_e),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    typedef struct {
        logic        sf, sd, fl, pe, rdy;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic        erv;
        logic [31:0] era;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t mq[$];
    int    cyc = 0;
    int    lat = 1;
    int    checks = 0;
    int    errors = 0;

    function automatic vec_t v(input logic sf, sd, fl, pe, rdy, input logic [31:0] tgt,
                               input logic ev, input logic [31:0] epc,
                               input logic erv, input logic [31:0] era);
        vec_t r;
        r.sf = sf; r.sd = sd; r.fl = fl; r.pe = pe; r.rdy = rdy; r.tgt = tgt;
        r.ev = ev; r.epc = epc; r.erv = erv; r.era = era;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory returns ~addr so every word identifies its own address
    task automatic step(input string seg, input int idx, input vec_t r);
        pend_t p;
        stall_f = r.sf; stall_d = r.sd; flush_d = r.fl; pcsrc_e = r.pe;
        imem_req_ready = r.rdy; pc_target_e = r.tgt;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            p = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~p.addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        chk($sformatf("%s[%0d] req_valid", seg, idx), {31'd0, imem_req_valid}, {31'd0, r.erv});
        if (r.erv) chk($sformatf("%s[%0d] req_addr", seg, idx), imem_req_addr, r.era);
        chk($sformatf("%s[%0d] valid_d", seg, idx), {31'd0, valid_d}, {31'd0, r.ev});
        chk($sformatf("%s[%0d] pc_d", seg, idx), pc_d, r.ev ? r.epc : 32'h0);
        chk($sformatf("%s[%0d] instr_d", seg, idx), instr_d, r.ev ? ~r.epc : 32'h0);
        chk($sformatf("%s[%0d] pc_plus4_d", seg, idx), pc_plus4_d, r.ev ? r.epc + 32'd4 : 32'h0);
        if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_reset(input string tag, input int new_lat);
        arst_n = 1'b0;
        #1;
        chk({tag, " rst req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, " rst valid_d"}, {31'd0, valid_d}, 32'd0);
        chk({tag, " rst pc_d"}, pc_d, 32'd0);
        chk({tag, " rst instr_d"}, instr_d, 32'd0);
        chk({tag, " rst pc_plus4_d"}, pc_plus4_d, 32'd0);
        mq.delete();
        imem_rsp_valid = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc_e = 1'b0; imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        lat = new_lat;
        arst_n = 1'b1;
    endtask

    initial begin
        vec_t seg_a[$];
        vec_t seg_b[$];
        vec_t seg_c[$];

        // A: 1-cycle memory; stall_d hold, flush, flush+stall, redirect with same-cycle response
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h000));
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h004));
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h008));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h000, 1, 32'h00C));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h004, 1, 32'h010));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h008, 1, 32'h014));
        seg_a.push_back(v(0,1,0,0,1, 0, 1, 32'h00C, 1, 32'h018));
        seg_a.push_back(v(0,1,0,0,1, 0, 1, 32'h00C, 1, 32'h01C));
        seg_a.push_back(v(0,1,0,0,1, 0, 1, 32'h00C, 0, 32'h000));
        seg_a.push_back(v(0,1,0,0,1, 0, 1, 32'h00C, 0, 32'h000));
        seg_a.push_back(v(0,1,0,0,1, 0, 1, 32'h00C, 0, 32'h000));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h00C, 0, 32'h000));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h010, 1, 32'h020));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h014, 1, 32'h024));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h018, 1, 32'h028));
        seg_a.push_back(v(0,0,1,0,1, 0, 1, 32'h01C, 1, 32'h02C));
        seg_a.push_back(v(0,1,1,0,1, 0, 0, 32'h000, 0, 32'h000));
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 0, 32'h000));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h020, 1, 32'h030));
        seg_a.push_back(v(0,0,0,1,1, 32'h103, 1, 32'h024, 0, 32'h000));
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h100));
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h104));
        seg_a.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h108));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h100, 1, 32'h10C));
        seg_a.push_back(v(0,0,0,0,1, 0, 1, 32'h104, 1, 32'h110));

        // B: 2-cycle memory; ready low holds the address, redirect to 0xFFFFFFFE wraps pc
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h000));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h004));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h008));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h00C));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'h000, 1, 32'h010));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'h004, 1, 32'h014));
        seg_b.push_back(v(0,0,0,0,0, 0, 1, 32'h008, 1, 32'h018));
        seg_b.push_back(v(0,0,0,0,0, 0, 1, 32'h00C, 1, 32'h018));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'h010, 1, 32'h018));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'h014, 1, 32'h01C));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h020));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h024));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'h018, 1, 32'h028));
        seg_b.push_back(v(0,0,0,1,1, 32'hFFFF_FFFE, 1, 32'h01C, 0, 32'h000));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'hFFFF_FFFC));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h000));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h004));
        seg_b.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h008));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'hFFFF_FFFC, 1, 32'h00C));
        seg_b.push_back(v(0,0,0,0,1, 0, 1, 32'h000, 1, 32'h010));

        // C: 3-cycle memory; redirect with 3 unanswered (one answering) drops two later responses
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h000));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h004));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h008));
        seg_c.push_back(v(0,0,0,1,1, 32'h103, 0, 32'h000, 0, 32'h000));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h100));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h104));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h108));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 1, 32'h10C));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 0, 32'h000));
        seg_c.push_back(v(0,0,0,0,1, 0, 1, 32'h100, 1, 32'h110));
        seg_c.push_back(v(0,0,0,0,1, 0, 1, 32'h104, 1, 32'h114));
        seg_c.push_back(v(0,0,0,0,1, 0, 1, 32'h108, 1, 32'h118));
        seg_c.push_back(v(0,0,0,0,1, 0, 1, 32'h10C, 1, 32'h11C));
        seg_c.push_back(v(0,0,0,0,1, 0, 0, 32'h000, 0, 32'h000));
        seg_c.push_back(v(1,0,0,0,1, 0, 1, 32'h110, 0, 32'h000));
        seg_c.push_back(v(0,0,0,0,1, 0, 1, 32'h114, 1, 32'h120));
        seg_c.push_back(v(0,0,0,0,1, 0, 1, 32'h118, 1, 32'h124));

        #2;
        pulse_reset("init", 1);
        foreach (seg_a[i]) step("A", i, seg_a[i]);

        // Mid-burst: IF/ID holds 0x108 here, reset must clear it without a clock edge
        pulse_reset("midA", 2);
        foreach (seg_b[i]) step("B", i, seg_b[i]);

        pulse_reset("midB", 3);
        foreach (seg_c[i]) step("C", i, seg_c[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
